cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the L1 cache's memory-side interface and converts one full-line transaction (read or write) into a fixed-length burst on the physical memory bus.
- Supports both refill (line read) and writeback (line write).
- The cache-facing side is line-wide with a single-cycle resp_o pulse.
- The memory-facing side moves one burst_width beat per resp_i pulse.

Parameters:
- s_line, 256, cache line width in bits.
- s_burst, 64, memory bus beat width in bits; s_line must be an integer multiple of s_burst.
- s_addr, 32, address width.
- n_beats, s_line/s_burst (derived, 4), beats per line.
- s_offset, log2(s_line/8) (derived, 5), byte-offset bits cleared on address_o.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- address_i  input  s_addr  line address from cache.
- read_i  input  1  line read request; held until resp_o.
- write_i  input  1  line write request; held until resp_o.
- line_i  input  s_line  writeback line data.
- line_o  output  s_line  refill line data.
- resp_o  output  1  one-cycle completion pulse to cache.
- address_o  output  s_addr  aligned burst address to memory.
- read_o  output  1  burst read request to memory.
- write_o  output  1  burst write request to memory.
- burst_o  output  s_burst  current write beat.
- burst_i  input  s_burst  read beat from memory.
- resp_i  input  1  memory beat accept/valid strobe.

Behaviour:
- Reset (rst=0, async): state=IDLE, beat counter=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0, internal line buffer=0. Takes effect immediately, including mid-burst; the partial transaction is discarded and no resp_o is issued.
- All outputs are registered; there is no combinational path from any input to any output.

FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - write_i=1: latch line_i into the buffer and address_i into address_o with the low s_offset bits zeroed; count=0; next WR_BURST. Write has priority if read_i and write_i are both 1.
  - read_i=1 (and write_i=0): latch the aligned address; count=0; next RD_BURST.
  - resp_i is ignored in IDLE.
- RD_BURST:
  - read_o=1 throughout.
  - Each cycle with resp_i=1: buffer beat[count] <= burst_i, where beat k occupies bits [k*s_burst +: s_burst]; count++.
  - When resp_i=1 and count==n_beats-1: next DONE, read_o deasserts.
- WR_BURST:
  - write_o=1 throughout; burst_o = buffer beat[count], updated the cycle after each accepted beat.
  - Each resp_i=1 consumes the beat currently on burst_o; count++.
  - On the last beat: next DONE.
- DONE:
  - resp_o=1 for exactly one cycle; next IDLE unconditionally.
  - On a read, line_o updates from the buffer on DONE entry and holds stable until the next read completes. Writes do not change line_o.
- Beat counter is log2(n_beats) bits and wraps to 0 on the last beat. It never exceeds n_beats-1.
- Latency with resp_i tied high: request sampled at cycle T, beats on T+1..T+4, resp_o at T+5. Each resp_i=0 cycle adds one cycle.
- Requests arriving in RD_BURST, WR_BURST or DONE are ignored.
  - The cache drops its request the cycle after resp_o.
  - A request still high in IDLE after DONE starts a new transaction; back-to-back issue gives a minimum of 1 IDLE cycle between transactions.
- address_o, read_o and write_o are stable for the whole burst. address_o holds its last value in IDLE.

Test Plan:
- Reset: drive rst=0 mid-WR_BURST after 2 beats -> all outputs 0 immediately, no resp_o, state IDLE; after rst=1 a fresh read completes normally.
- Read, resp_i tied high:
  - Stimulus: address_i=0x0000_1234, beats 0x0..0_A0, 0x0..0_A1, 0x0..0_A2, 0x0..0_A3.
  - Required: address_o=0x0000_1220; read_o high cycles T+1..T+4; resp_o at T+5; line_o={A3,A2,A1,A0} in 64-bit lanes.
- Read with stalls: resp_i pattern 1,0,0,1,1,0,1 -> resp_o exactly one cycle after the 4th accepted beat (T+8); line_o is correct.
- Write:
  - Stimulus: line_i=0x4444..._3333..._2222..._1111..., resp_i tied high.
  - Required: burst_o presents 0x1111...,0x2222...,0x3333...,0x4444... in order; write_o high for 4 cycles; one resp_o pulse; line_o unchanged.
- Simultaneous read_i=write_i=1: write burst performed (write_o=1, read_o never asserted), single resp_o.
- Back-to-back: writeback then refill (cache victim eviction) -> two resp_o pulses, one IDLE cycle between them; refill data is correct and the writeback data is intact on the bus.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Converts a line-wide cache refill/writeback into a fixed-length burst of
// s_burst-wide beats on the memory bus; all outputs are registered.
module cacheline_adaptor #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64,
  parameter int unsigned s_addr  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_addr-1:0]   address_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  output logic                resp_o,
  output logic [s_addr-1:0]   address_o,
  output logic                read_o,
  output logic                write_o,
  output logic [s_burst-1:0]  burst_o,
  input  logic [s_burst-1:0]  burst_i,
  input  logic                resp_i
);

  localparam int unsigned n_beats  = s_line / s_burst;
  localparam int unsigned s_offset = $clog2(s_line / 8);
  localparam int unsigned cnt_w    = (n_beats > 1) ? $clog2(n_beats) : 1;
  localparam logic [s_addr-1:0] addr_mask =
    {{(s_addr - s_offset){1'b1}}, {s_offset{1'b0}}};

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;
  typedef logic [n_beats-1:0][s_burst-1:0] beats_t;

  state_e               state_q, state_d;
  logic [cnt_w-1:0]     count_q, count_d;
  beats_t               buf_q, buf_d;
  logic [s_addr-1:0]    addr_q, addr_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic                 resp_q, resp_d;
  logic [s_burst-1:0]   burst_q, burst_d;
  logic [s_line-1:0]    line_q, line_d;
  logic                 last_beat_c;

  assign last_beat_c = (count_q == cnt_w'(n_beats - 1));

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    resp_d  = 1'b0;
    burst_d = burst_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        // Writeback wins when both requests are raised together
        if (write_i) begin
          buf_d   = line_i;
          addr_d  = address_i & addr_mask;
          count_d = '0;
          burst_d = line_i[s_burst-1:0];
          write_d = 1'b1;
          state_d = WR_BURST;
        end else if (read_i) begin
          addr_d  = address_i & addr_mask;
          count_d = '0;
          read_d  = 1'b1;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        read_d = 1'b1;
        if (resp_i) begin
          buf_d[count_q] = burst_i;
          count_d        = count_q + cnt_w'(1);
          if (last_beat_c) begin
            read_d  = 1'b0;
            resp_d  = 1'b1;
            line_d  = buf_d;
            state_d = DONE;
          end
        end
      end
      WR_BURST: begin
        write_d = 1'b1;
        if (resp_i) begin
          count_d = count_q + cnt_w'(1);
          if (last_beat_c) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end else begin
            burst_d = buf_q[count_q + cnt_w'(1)];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
      burst_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
      burst_q <= burst_d;
      line_q  <= line_d;
    end
  end

  assign line_o    = line_q;
  assign resp_o    = resp_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign burst_o   = burst_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor: refill, stalled refill,
// writeback, read/write collision, back-to-back and mid-burst reset.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int n_cmp = 0;
  int n_err = 0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Refill: bench memory returns beat k of exp_line on the k-th accepted strobe
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [255:0] exp_line, input logic [15:0] pat, input int plen,
                         input int exp_lat, input bit b2b);
    logic [3:0][63:0] bv;
    int acc, lat, rd_hi, idx;
    bv = exp_line;
    acc = 0; lat = 0; rd_hi = 0; idx = 0;
    address_i = addr;
    read_i    = 1'b1;
    resp_i    = 1'b0;
    step();
    if (b2b) begin
      check({tag, "_idle_gap"}, {resp_o, read_o, write_o}, 3'b000);
      step();
    end
    check({tag, "_addr"}, address_o, exp_addr);
    for (int n = 1; n <= 40; n++) begin
      if (resp_o) begin
        lat = n;
        break;
      end
      if (read_o) rd_hi++;
      resp_i  = (idx < plen) ? pat[idx] : 1'b1;
      idx++;
      burst_i = (resp_i && acc < 4) ? bv[acc] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (resp_i) acc++;
      step();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    check({tag, "_latency"}, 256'(lat), 256'(exp_lat));
    check({tag, "_read_o_cycles"}, 256'(rd_hi), 256'(exp_lat - 1));
    check({tag, "_line_o"}, line_o, exp_line);
    check({tag, "_read_o_low"}, read_o, 1'b0);
  endtask

  // Writeback with resp_i tied high; both=1 raises read_i alongside write_i
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [255:0] line, input bit both, input logic [255:0] exp_line_o);
    logic [3:0][63:0] bv;
    int acc, lat, wr_hi;
    bv = line;
    acc = 0; lat = 0; wr_hi = 0;
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
    read_i    = both;
    resp_i    = 1'b0;
    step();
    check({tag, "_addr"}, address_o, exp_addr);
    for (int n = 1; n <= 40; n++) begin
      if (resp_o) begin
        lat = n;
        break;
      end
      if (write_o) wr_hi++;
      if (acc < 4) check({tag, "_beat"}, burst_o, bv[acc]);
      check({tag, "_read_o_quiet"}, read_o, 1'b0);
      resp_i = 1'b1;
      acc++;
      step();
    end
    resp_i  = 1'b0;
    write_i = 1'b0;
    read_i  = 1'b0;
    check({tag, "_latency"}, 256'(lat), 256'(5));
    check({tag, "_write_o_cycles"}, 256'(wr_hi), 256'(4));
    check({tag, "_line_o_kept"}, line_o, exp_line_o);
    check({tag, "_write_o_low"}, write_o, 1'b0);
  endtask

  localparam logic [255:0] L_RD1 = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
  localparam logic [255:0] L_RD2 = {64'h0B0B_0000_0000_00B3, 64'h0B0B_0000_0000_00B2,
                                    64'h0B0B_0000_0000_00B1, 64'h0B0B_0000_0000_00B0};
  localparam logic [255:0] L_WR1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L_WR2 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] L_WB  = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                                    64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
  localparam logic [255:0] L_RF  = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                                    64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
  localparam logic [255:0] L_RST = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                                    64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
  localparam logic [255:0] L_RD3 = {64'hF3, 64'hF2, 64'hF1, 64'hF0};

  initial begin
    bit stray_resp;
    rst       = 1'b1;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ctrl", {resp_o, read_o, write_o}, 3'b000);
    check("reset_addr", address_o, 32'h0);
    check("reset_line", line_o, 256'h0);
    rst = 1'b1;
    step();
    check("idle_quiet", {resp_o, read_o, write_o}, 3'b000);

    do_read("rd_fast", 32'h0000_1234, 32'h0000_1220, L_RD1, 16'h0000, 0, 5, 1'b0);
    step();
    check("rd_fast_single_resp", resp_o, 1'b0);

    do_read("rd_stall", 32'h0000_ABFF, 32'h0000_ABE0, L_RD2, 16'h0059, 7, 8, 1'b0);
    step();
    check("rd_stall_single_resp", resp_o, 1'b0);
    check("rd_stall_line_hold", line_o, L_RD2);

    do_write("wr", 32'h8000_003F, 32'h8000_0020, L_WR1, 1'b0, L_RD2);
    step();
    check("wr_single_resp", resp_o, 1'b0);

    do_write("wr_rd_both", 32'h0000_0040, 32'h0000_0040, L_WR2, 1'b1, L_RD2);
    step();
    check("wr_rd_both_single_resp", resp_o, 1'b0);

    do_write("b2b_wb", 32'h2000_0047, 32'h2000_0040, L_WB, 1'b0, L_RD2);
    do_read("b2b_rf", 32'h1000_0010, 32'h1000_0000, L_RF, 16'h0000, 0, 5, 1'b1);
    check("b2b_wb_data_on_bus", burst_o, 64'h5555_0000_0000_0003);
    step();
    check("b2b_single_resp", resp_o, 1'b0);

    // Abort a writeback after two accepted beats
    address_i = 32'h3000_0000;
    line_i    = L_RST;
    write_i   = 1'b1;
    step();
    resp_i = 1'b1;
    step();
    step();
    check("rst_pre_write_o", write_o, 1'b1);
    check("rst_pre_beat2", burst_o, 64'h7777_0000_0000_0003);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_ctrl", {resp_o, read_o, write_o}, 3'b000);
    check("rst_mid_addr", address_o, 32'h0);
    check("rst_mid_burst", burst_o, 64'h0);
    check("rst_mid_line", line_o, 256'h0);
    write_i = 1'b0;
    resp_i  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    resp_i = 1'b1;
    stray_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (resp_o || read_o || write_o) stray_resp = 1'b1;
    end
    resp_i = 1'b0;
    check("rst_no_stray_activity", stray_resp, 1'b0);

    do_read("rd_after_rst", 32'h0000_0F1F, 32'h0000_0F00, L_RD3, 16'h0000, 0, 5, 1'b0);
    step();
    check("rd_after_rst_single_resp", resp_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
